// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer around the combinational SimpleRISC ALU: operand registers, latency count, capture, flags.
// Optional feature macro ALU_EXEC_DIVZERO_EN: div/mod by zero yields all-ones result and asserts div_zero.
module alu_exec_ctrl #(
  parameter int DATA_W     = 32,
  parameter int RD_W       = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RD_W-1:0]   in_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_sig,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [1:0]        alu_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  output logic [1:0]        out_mem,
  output logic [1:0]        flags_q,
  output logic              illegal_op,
  output logic              div_zero
);

  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_NOP = 5'd13;
  localparam logic [4:0] OP_LD  = 5'd14;
  localparam logic [4:0] OP_ST  = 5'd15;
  localparam logic [3:0] LAT_MD = 4'(MULDIV_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_div_zero;
  logic [3:0]          r_cnt;
  logic [4:0]          r_op;
  logic [RD_W-1:0]     r_rd;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [4:0]          r_alu_sig;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_result;
  logic [RD_W-1:0]     r_out_rd;
  logic                r_out_wb_en;
  logic [1:0]          r_out_mem;
  logic [1:0]          r_flags;
  logic                r_illegal;
  logic                r_div_zero;

  function automatic logic [3:0] f_lat(input logic [4:0] op);
    if (op == OP_MUL || op == OP_DIV || op == OP_MOD) begin
      return LAT_MD;
    end else begin
      return 4'd1;
    end
  endfunction

  // Ops that write a GPR: arithmetic/logic group, excluding cmp, nop, ld, st and illegal codes
  function automatic logic f_wb(input logic [4:0] op);
    return (op <= OP_MOD) || ((op > OP_CMP) && (op < OP_NOP));
  endfunction

  function automatic logic [1:0] f_mem(input logic [4:0] op);
    case (op)
      OP_LD:   return 2'b10;
      OP_ST:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

`ifdef ALU_EXEC_DIVZERO_EN
  assign w_div_zero = ((r_op == OP_DIV) || (r_op == OP_MOD)) && (r_alu_b == {DATA_W{1'b0}});
`else
  assign w_div_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and capture strobes
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, latency counter, result capture and architectural flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_op         <= OP_NOP;
      r_rd         <= {RD_W{1'b0}};
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_alu_sig    <= OP_NOP;
      r_out_valid  <= 1'b0;
      r_out_result <= {DATA_W{1'b0}};
      r_out_rd     <= {RD_W{1'b0}};
      r_out_wb_en  <= 1'b0;
      r_out_mem    <= 2'b00;
      r_flags      <= 2'b00;
      r_illegal    <= 1'b0;
      r_div_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= in_a;
        r_alu_b   <= in_b;
        r_alu_sig <= in_op[4] ? OP_NOP : in_op;
        r_op      <= in_op;
        r_rd      <= in_rd;
        r_cnt     <= f_lat(in_op);
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end

      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= r_rd;
        r_out_mem   <= f_mem(r_op);
        r_illegal   <= r_op[4];
        r_div_zero  <= w_div_zero;
        r_out_wb_en <= f_wb(r_op);
        if (r_op[4]) begin
          r_out_result <= {DATA_W{1'b0}};
        end else if (w_div_zero) begin
          r_out_result <= {DATA_W{1'b1}};
        end else begin
          r_out_result <= alu_result;
        end
        if (r_op == OP_CMP) begin
          r_flags <= alu_flags;
        end else begin
          r_flags <= r_flags;
        end
      end else if ((r_state == S_DONE) && out_ready) begin
        // Status pulses are qualified by out_valid, so drop them with it
        r_out_valid <= 1'b0;
        r_illegal   <= 1'b0;
        r_div_zero  <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sig    = r_alu_sig;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_wb_en  = r_out_wb_en;
  assign out_mem    = r_out_mem;
  assign flags_q    = r_flags;
  assign illegal_op = r_illegal;
  assign div_zero   = r_div_zero;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU on the alu_* interface.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_rd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sig;
  logic [31:0] alu_result;
  logic [1:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wb_en;
  logic [1:0]  out_mem;
  logic [1:0]  flags_q;
  logic        illegal_op;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic seen;

  alu_exec_ctrl #(.DATA_W(32), .RD_W(4), .MULDIV_LAT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sig(alu_sig),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_mem(out_mem),
    .flags_q(flags_q), .illegal_op(illegal_op), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU (subset of SimpleRISC ops)
  always_comb begin
    alu_result = 32'd0;
    alu_flags  = 2'b00;
    case (alu_sig)
      5'd0, 5'd14, 5'd15: alu_result = alu_a + alu_b;
      5'd1: alu_result = alu_a - alu_b;
      5'd2: alu_result = alu_a * alu_b;
      5'd3: alu_result = (alu_b != 32'd0) ? alu_a / alu_b : 32'd0;
      5'd4: alu_result = (alu_b != 32'd0) ? alu_a % alu_b : 32'd0;
      5'd5: alu_flags  = {alu_a > alu_b, alu_a == alu_b};
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd);
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 5'd0; in_a = 32'd0; in_b = 32'd0; in_rd = 4'd0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_alu_sig", 32'(alu_sig), 32'd13);
    check_eq("rst_flags", 32'(flags_q), 32'd0);
    check_eq("rst_result", out_result, 32'd0);

    // add: one-cycle latency
    issue(5'd0, 32'd5, 32'd7, 4'd3);
    check_eq("add_busy", 32'(in_ready), 32'd0);
    wait_valid(cyc);
    check_eq("add_lat", 32'(cyc), 32'd1);
    check_eq("add_res", out_result, 32'd12);
    check_eq("add_wb", 32'(out_wb_en), 32'd1);
    check_eq("add_rd", 32'(out_rd), 32'd3);
    tick();
    check_eq("add_drop", 32'(out_valid), 32'd0);

    // mul: MULDIV_LAT cycles, busy meanwhile
    issue(5'd2, 32'd3, 32'd9, 4'd5);
    check_eq("mul_busy", 32'(in_ready), 32'd0);
    wait_valid(cyc);
    check_eq("mul_lat", 32'(cyc), 32'd4);
    check_eq("mul_res", out_result, 32'd27);
    tick();

    // cmp updates flags, add leaves them alone
    issue(5'd5, 32'd9, 32'd4, 4'd1);
    wait_valid(cyc);
    check_eq("cmp1_flags", 32'(flags_q), 32'd2);
    check_eq("cmp1_wb", 32'(out_wb_en), 32'd0);
    tick();
    issue(5'd5, 32'd4, 32'd4, 4'd1);
    wait_valid(cyc);
    check_eq("cmp2_flags", 32'(flags_q), 32'd1);
    tick();
    issue(5'd0, 32'd1, 32'd1, 4'd1);
    wait_valid(cyc);
    check_eq("add_keep_flags", 32'(flags_q), 32'd1);
    tick();

    // Backpressure, then combined out+in handshake
    out_ready = 1'b0;
    issue(5'd1, 32'd20, 32'd8, 4'd7);
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_res", out_result, 32'd12);
      check_eq("stall_rd", 32'(out_rd), 32'd7);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    issue(5'd0, 32'd100, 32'd1, 4'd2);
    check_eq("b2b_valid", 32'(out_valid), 32'd0);
    check_eq("b2b_alu_a", alu_a, 32'd100);
    wait_valid(cyc);
    check_eq("b2b_lat", 32'(cyc), 32'd1);
    check_eq("b2b_res", out_result, 32'd101);
    check_eq("b2b_rd", 32'(out_rd), 32'd2);
    tick();

    // Division, normal and by zero
    issue(5'd3, 32'd10, 32'd3, 4'd4);
    wait_valid(cyc);
    check_eq("div_res", out_result, 32'd3);
    check_eq("div_dz", 32'(div_zero), 32'd0);
    tick();
    issue(5'd3, 32'd10, 32'd0, 4'd4);
    wait_valid(cyc);
    check_eq("div0_lat", 32'(cyc), 32'd4);
`ifdef ALU_EXEC_DIVZERO_EN
    check_eq("div0_res", out_result, 32'hFFFF_FFFF);
    check_eq("div0_dz", 32'(div_zero), 32'd1);
    check_eq("div0_wb", 32'(out_wb_en), 32'd1);
`else
    check_eq("div0_res", out_result, 32'd0);
    check_eq("div0_dz", 32'(div_zero), 32'd0);
`endif
    tick();

    // Illegal opcode
    issue(5'b10101, 32'd6, 32'd6, 4'd9);
    check_eq("ill_sig", 32'(alu_sig), 32'd13);
    wait_valid(cyc);
    check_eq("ill_lat", 32'(cyc), 32'd1);
    check_eq("ill_flag", 32'(illegal_op), 32'd1);
    check_eq("ill_wb", 32'(out_wb_en), 32'd0);
    check_eq("ill_res", out_result, 32'd0);
    check_eq("ill_flags", 32'(flags_q), 32'd1);
    tick();
    check_eq("ill_clear", 32'(illegal_op), 32'd0);

    // Memory ops
    issue(5'd14, 32'h100, 32'd4, 4'd6);
    wait_valid(cyc);
    check_eq("ld_mem", 32'(out_mem), 32'd2);
    check_eq("ld_res", out_result, 32'h104);
    check_eq("ld_wb", 32'(out_wb_en), 32'd0);
    tick();
    issue(5'd15, 32'h200, 32'd8, 4'd6);
    wait_valid(cyc);
    check_eq("st_mem", 32'(out_mem), 32'd1);
    tick();

    // Reset in the middle of a multi-cycle op
    issue(5'd2, 32'd2, 32'd2, 4'd1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rmid_valid", 32'(out_valid), 32'd0);
    check_eq("rmid_flags", 32'(flags_q), 32'd0);
    check_eq("rmid_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check_eq("rmid_no_valid", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
